puls_hnd_shk_rx_mc: RTL and testbench
=====================================

Name: puls_hnd_shk_rx_mc

Overview:
- Multi-channel, destination-side receiver for pulse/handshake CDC in the PUF SoC.
- Takes NUM_CH asynchronous request lines from foreign clock domains and synchronises each through an NUM_FF-deep flop chain.
- Detects request edges, either rising only (4-phase) or both edges (2-phase toggle), and queues them as counted events.
- Presents events to local consumers with a valid/ready handshake and returns the synchronised request level as the ack for source-side feedback.

Parameters:
- NUM_CH, 4, number of independent channels (1..32).
- NUM_FF, 2, synchroniser depth per channel (2..4).
- EDGE_MODE, 0, 0 = rising edge only (4-phase req/ack); 1 = both edges (2-phase toggle).
- CNT_W, 3, width of per-channel pending-event counter; saturates at 2^CNT_W-1.

Ports:
- clk, input, 1, single local clock.
- rst, input, 1, synchronous active-high reset.
- i_req, input, NUM_CH, asynchronous request levels or toggles, one per channel.
- o_ack, output, NUM_CH, synchronised request level (last chain stage), fed back to sources.
- o_evt_vld, output, NUM_CH, channel has at least one pending event.
- i_evt_rdy, input, NUM_CH, consumer accepts one event for that channel.
- o_pend_cnt, output, NUM_CH*CNT_W, pending count per channel; channel c occupies bits [c*CNT_W +: CNT_W].
- o_ovf, output, NUM_CH, sticky overflow flag per channel.
- i_ovf_clr, input, NUM_CH, clears o_ovf per channel.
- o_armed, output, 1, edge detection enabled after reset settle.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: all sync flops, history flops, counters, o_ovf, o_armed and o_ack are 0. o_evt_vld=0 and o_pend_cnt=0.
- Sync chain: per channel, NUM_FF flops, followed by one history flop r_prev holding the previous value of the last stage s.
- Edge detect: EDGE_MODE=0 uses s & ~r_prev. EDGE_MODE=1 uses s ^ r_prev. Detection is gated by o_armed.
- Arming: after rst deasserts, an arm counter runs NUM_FF+1 cycles, then o_armed=1, which stays set until the next rst.
  - This suppresses spurious events from inputs already high or mid-toggle at reset.
- Latency: i_req changes before clk edge k gives o_ack change after edge k+NUM_FF-1.
  - The pending counter increments after edge k+NUM_FF, so o_evt_vld rises after edge k+NUM_FF. With NUM_FF=2 that is 2 edges.
- Handshake: o_evt_vld = (pend != 0), driven straight from the registered counter. A consume happens on an edge with o_evt_vld & i_evt_rdy.
  - Decrement 1 per consume.
  - i_evt_rdy with o_evt_vld=0 is ignored.
- Counter update:
  - Event and consume in the same cycle: count unchanged.
  - Event only: count+1, unless saturated.
  - Consume only: count-1.
- Saturation: an event arriving at count=2^CNT_W-1 with no simultaneous consume is dropped; the count holds at max.
- Channels are fully independent; no arbitration between them.
- Reset mid-operation: synchronous clear of everything. Pending events are lost and arming restarts.

Optional Feature:
- Macro: PULS_HND_SHK_OVF_EN.
- Defined: a dropped event sets o_ovf[c]. i_ovf_clr[c] clears it on the next edge. If set and clear coincide, set wins.
- Undefined: o_ovf is tied 0, i_ovf_clr is unused, and drops are silent.

Decomposition:
- Package puls_sync_pkg holds:
  - EDGE_RISE=0 and EDGE_BOTH=1 constants.
  - NUM_FF_MIN=2 and NUM_FF_MAX=4 limits.
  - A saturating-count-next function taking (cnt, inc, dec, width).
- Sub-module puls_sync_ch is natural: one channel containing the sync chain, history flop, edge detect, counter and ovf flag.
  - The top level instantiates NUM_CH copies in a generate loop.
  - The top level owns the shared arm counter.

Test Plan:
- Reset release with i_req[0]=1 held, EDGE_MODE=0: o_armed rises after 3 cycles; o_evt_vld[0] stays 0 with no spurious event.
- EDGE_MODE=0, NUM_FF=2, i_req[1] 0->1 before edge 10, i_evt_rdy=0: o_ack[1]=1 after edge 11; o_evt_vld[1]=1 and o_pend_cnt ch1=1 after edge 12.
- EDGE_MODE=1, i_req[2] toggles 3 times, 6 cycles apart, i_evt_rdy=0: count=3. Then hold i_evt_rdy[2]=1: o_evt_vld[2] drops after 3 edges.
- CNT_W=3, 9 toggles on ch0 with no consume: count saturates at 7. With PULS_HND_SHK_OVF_EN defined, o_ovf[0]=1; pulsing i_ovf_clr[0] clears it.
- Event detect and consume on the same edge with count=2: count stays 2.
- Assert rst for 1 cycle while pending count is 5: count=0, o_evt_vld=0, o_armed=0; re-arms after NUM_FF+1 cycles.

Source files
------------

// File: rtl/puls_sync_pkg.sv
// puls_sync_pkg: shared constants and saturating counter helper for the pulse/handshake CDC receiver
package puls_sync_pkg;
   localparam int EDGE_RISE  = 0;
   localparam int EDGE_BOTH  = 1;
   localparam int NUM_FF_MIN = 2;
   localparam int NUM_FF_MAX = 4;

   function automatic logic [31:0] sat_cnt_next(
      input logic [31:0] cnt,
      input logic        inc,
      input logic        dec,
      input int unsigned width
   );
      logic [31:0] max;
      max = (32'd1 << width) - 32'd1;
      return (inc && !dec) ? ((cnt == max) ? cnt : cnt + 32'd1) :
             (dec && !inc) ? cnt - 32'd1 : cnt;
   endfunction
endpackage

// File: rtl/puls_sync_ch.sv
// puls_sync_ch: one receiver channel (sync chain, edge detect, pending counter, overflow flag when PULS_HND_SHK_OVF_EN is defined)
module puls_sync_ch
   import puls_sync_pkg::*;
#(
   parameter int NUM_FF    = NUM_FF_MIN,
   parameter int EDGE_MODE = EDGE_RISE,
   parameter int CNT_W     = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_armed,
   input  logic             i_req,
   input  logic             i_evt_rdy,
   input  logic             i_ovf_clr,
   output logic             o_ack,
   output logic             o_evt_vld,
   output logic [CNT_W-1:0] o_pend_cnt,
   output logic             o_ovf
);
   logic [NUM_FF-1:0] sync_q, sync_d;
   logic              prev_q, prev_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              s, evt, cons, drop;

   // Shift the request through the synchroniser, detect edges and compute the next pending count
   always_comb begin
      s      = sync_q[NUM_FF-1];
      sync_d = {sync_q[NUM_FF-2:0], i_req};
      prev_d = s;
      evt    = i_armed & ((EDGE_MODE == EDGE_BOTH) ? (s ^ prev_q) : (s & ~prev_q));
      cons   = (cnt_q != '0) & i_evt_rdy;
      drop   = evt & ~cons & (cnt_q == '1);
      cnt_d  = CNT_W'(sat_cnt_next(32'(cnt_q), evt, cons, CNT_W));
   end

   // Channel state registers
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
         prev_q <= 1'b0;
         cnt_q  <= '0;
      end else begin
         sync_q <= sync_d;
         prev_q <= prev_d;
         cnt_q  <= cnt_d;
      end
   end

   assign o_ack      = s;
   assign o_evt_vld  = cnt_q != '0;
   assign o_pend_cnt = cnt_q;

`ifdef PULS_HND_SHK_OVF_EN
   logic ovf_q, ovf_d;

   // Sticky overflow: a dropped event wins over a simultaneous clear
   always_comb begin
      ovf_d = drop | (ovf_q & ~i_ovf_clr);
   end

   // Overflow flag register
   always_ff @(posedge clk) begin
      if (rst) ovf_q <= 1'b0;
      else     ovf_q <= ovf_d;
   end

   assign o_ovf = ovf_q;
`else
   logic unused_ovf;
   assign unused_ovf = drop ^ i_ovf_clr;
   assign o_ovf      = 1'b0;
`endif
endmodule

// File: rtl/puls_hnd_shk_rx_mc.sv
// puls_hnd_shk_rx_mc: multi-channel pulse/handshake CDC receiver; overflow flags enabled by PULS_HND_SHK_OVF_EN
module puls_hnd_shk_rx_mc
   import puls_sync_pkg::*;
#(
   parameter int NUM_CH    = 4,
   parameter int NUM_FF    = 2,
   parameter int EDGE_MODE = EDGE_RISE,
   parameter int CNT_W     = 3
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_CH-1:0]       i_req,
   output logic [NUM_CH-1:0]       o_ack,
   output logic [NUM_CH-1:0]       o_evt_vld,
   input  logic [NUM_CH-1:0]       i_evt_rdy,
   output logic [NUM_CH*CNT_W-1:0] o_pend_cnt,
   output logic [NUM_CH-1:0]       o_ovf,
   input  logic [NUM_CH-1:0]       i_ovf_clr,
   output logic                    o_armed
);
   localparam int NFF   = (NUM_FF < NUM_FF_MIN) ? NUM_FF_MIN : (NUM_FF > NUM_FF_MAX) ? NUM_FF_MAX : NUM_FF;
   localparam int ARM_W = $clog2(NUM_FF_MAX + 1);

   logic [ARM_W-1:0] arm_cnt_q, arm_cnt_d;
   logic             armed_q, armed_d;

   // Arm after the sync chain and history flop have flushed their reset values (NFF+1 cycles)
   always_comb begin
      arm_cnt_d = armed_q ? arm_cnt_q : arm_cnt_q + ARM_W'(1);
      armed_d   = armed_q | (arm_cnt_q == ARM_W'(NFF));
   end

   // Arm counter registers
   always_ff @(posedge clk) begin
      if (rst) begin
         arm_cnt_q <= '0;
         armed_q   <= 1'b0;
      end else begin
         arm_cnt_q <= arm_cnt_d;
         armed_q   <= armed_d;
      end
   end

   assign o_armed = armed_q;

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      puls_sync_ch #(
         .NUM_FF   (NFF),
         .EDGE_MODE(EDGE_MODE),
         .CNT_W    (CNT_W)
      ) u_ch (
         .clk       (clk),
         .rst       (rst),
         .i_armed   (armed_q),
         .i_req     (i_req[c]),
         .i_evt_rdy (i_evt_rdy[c]),
         .i_ovf_clr (i_ovf_clr[c]),
         .o_ack     (o_ack[c]),
         .o_evt_vld (o_evt_vld[c]),
         .o_pend_cnt(o_pend_cnt[c*CNT_W +: CNT_W]),
         .o_ovf     (o_ovf[c])
      );
   end
endmodule

// File: tb/tb_puls_hnd_shk_rx_mc.sv
// tb_puls_hnd_shk_rx_mc: directed scoreboard bench for rising-edge and toggle receiver builds
module tb_puls_hnd_shk_rx_mc;
   localparam logic OVF_EXP =
`ifdef PULS_HND_SHK_OVF_EN
      1'b1;
`else
      1'b0;
`endif

   typedef struct {
      string       tag;
      logic [31:0] exp;
   } sb_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  req_a = '0, rdy_a = '0, clr_a = '0, ack_a, vld_a, ovf_a;
   logic [3:0]  req_b = '0, rdy_b = '0, clr_b = '0, ack_b, vld_b, ovf_b;
   logic [11:0] cnt_a, cnt_b;
   logic        armed_a, armed_b;
   sb_t         sb[$];
   int          total = 0;
   int          bad = 0;
   int          cons_b[4] = '{default: 0};

   always #5 clk = ~clk;

   puls_hnd_shk_rx_mc #(.NUM_CH(4), .NUM_FF(2), .EDGE_MODE(0), .CNT_W(3)) dut_a (
      .clk(clk), .rst(rst), .i_req(req_a), .o_ack(ack_a), .o_evt_vld(vld_a), .i_evt_rdy(rdy_a),
      .o_pend_cnt(cnt_a), .o_ovf(ovf_a), .i_ovf_clr(clr_a), .o_armed(armed_a)
   );

   puls_hnd_shk_rx_mc #(.NUM_CH(4), .NUM_FF(2), .EDGE_MODE(1), .CNT_W(3)) dut_b (
      .clk(clk), .rst(rst), .i_req(req_b), .o_ack(ack_b), .o_evt_vld(vld_b), .i_evt_rdy(rdy_b),
      .o_pend_cnt(cnt_b), .o_ovf(ovf_b), .i_ovf_clr(clr_b), .o_armed(armed_b)
   );

   always @(posedge clk) begin
      for (int c = 0; c < 4; c++) if (!rst && vld_b[c] && rdy_b[c]) cons_b[c]++;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic push(input string tag, input logic [31:0] exp);
      sb.push_back('{tag: tag, exp: exp});
   endtask

   task automatic pop_chk(input logic [31:0] obs);
      sb_t e;
      if (sb.size() == 0) begin
         total++;
         bad++;
         $error("FAIL sb_underflow observed=%0d expected=entry", obs);
      end else begin
         e = sb.pop_front();
         chk(e.tag, obs, e.exp);
      end
   endtask

   function automatic logic [31:0] cnt_of(input logic [11:0] v, input int c);
      return 32'(v[c*3 +: 3]);
   endfunction

   initial begin
      req_a = 4'b0001;
      tick(2);
      chk("rst_armed", 32'(armed_a), 0);
      chk("rst_vld", 32'(vld_a), 0);
      chk("rst_cnt", 32'(cnt_a), 0);
      chk("rst_ack", 32'(ack_a), 0);
      rst = 1'b0;
      tick(2);
      chk("arm_early", 32'(armed_a), 0);
      tick(1);
      chk("arm_a", 32'(armed_a), 1);
      chk("arm_b", 32'(armed_b), 1);
      tick(3);
      chk("no_spurious_vld", 32'(vld_a), 0);
      chk("held_ack0", 32'(ack_a[0]), 1);

      req_a[1] = 1'b1;
      push("ack1_e1", 0); push("ack1_e2", 1); push("vld1_e2", 0); push("vld1_e3", 1); push("cnt1_e3", 1);
      tick(1); pop_chk(32'(ack_a[1]));
      tick(1); pop_chk(32'(ack_a[1])); pop_chk(32'(vld_a[1]));
      tick(1); pop_chk(32'(vld_a[1])); pop_chk(cnt_of(cnt_a, 1));
      req_a[1] = 1'b0;
      push("fall_no_evt", 1);
      tick(4); pop_chk(cnt_of(cnt_a, 1));
      rdy_a[1] = 1'b1;
      push("cons1", 0);
      tick(1); pop_chk(cnt_of(cnt_a, 1));
      push("rdy_idle", 0);
      tick(2); pop_chk(cnt_of(cnt_a, 1));
      rdy_a[1] = 1'b0;

      push("tgl_cnt", 3);
      for (int i = 0; i < 3; i++) begin
         req_b[2] = ~req_b[2];
         tick(6);
      end
      pop_chk(cnt_of(cnt_b, 2));
      rdy_b[2] = 1'b1;
      push("drain_e1", 2); push("drain_e2", 1); push("vld2_e2", 1); push("drain_e3", 0); push("vld2_e3", 0);
      tick(1); pop_chk(cnt_of(cnt_b, 2));
      tick(1); pop_chk(cnt_of(cnt_b, 2)); pop_chk(32'(vld_b[2]));
      tick(1); pop_chk(cnt_of(cnt_b, 2)); pop_chk(32'(vld_b[2]));
      rdy_b[2] = 1'b0;
      chk("cons2", 32'(cons_b[2]), 3);

      push("sat_cnt", 7); push("sat_ovf", 32'(OVF_EXP));
      for (int i = 0; i < 9; i++) begin
         req_b[0] = ~req_b[0];
         tick(2);
      end
      tick(2);
      pop_chk(cnt_of(cnt_b, 0)); pop_chk(32'(ovf_b[0]));
      clr_b[0] = 1'b1;
      push("ovf_clr", 0);
      tick(1);
      clr_b[0] = 1'b0;
      pop_chk(32'(ovf_b[0]));

      rdy_b[0] = 1'b1;
      push("drain_to2", 2);
      tick(5);
      rdy_b[0] = 1'b0;
      pop_chk(cnt_of(cnt_b, 0));
      req_b[0] = ~req_b[0];
      tick(2);
      rdy_b[0] = 1'b1;
      push("same_edge", 2);
      tick(1);
      rdy_b[0] = 1'b0;
      pop_chk(cnt_of(cnt_b, 0));
      chk("cons0", 32'(cons_b[0]), 6);

      push("pre_rst", 5);
      for (int i = 0; i < 5; i++) begin
         req_a[3] = 1'b1;
         tick(2);
         req_a[3] = 1'b0;
         tick(2);
      end
      pop_chk(cnt_of(cnt_a, 3));
      rst = 1'b1;
      push("mid_rst_cnt", 0); push("mid_rst_vld", 0); push("mid_rst_armed", 0);
      tick(1);
      pop_chk(32'(cnt_a)); pop_chk(32'(vld_a)); pop_chk(32'(armed_a));
      rst = 1'b0;
      tick(2);
      chk("rearm_early", 32'(armed_a), 0);
      tick(1);
      chk("rearm", 32'(armed_a), 1);
      tick(3);
      chk("rearm_vld_a", 32'(vld_a), 0);
      chk("rearm_vld_b", 32'(vld_b), 0);
      chk("sb_empty", 32'(sb.size()), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
